// File: rtl/led_drv_pkg.sv
// Shared constants, types and helpers for the LED afterglow PWM driver.
package led_drv_pkg;

  localparam int NUM_LEDS_DEF = 14;
  localparam int PWM_BITS_DEF = 8;
  localparam int FADE_DIV_DEF = 4096;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Square-law brightness curve: (lvl*lvl) >> PWM_BITS, keeping the full-width product.
  function automatic level_t gamma_sq(input level_t lvl);
    logic [2*PWM_BITS_DEF-1:0] prod;
    prod = {{PWM_BITS_DEF{1'b0}}, lvl} * {{PWM_BITS_DEF{1'b0}}, lvl};
    return prod[2*PWM_BITS_DEF-1:PWM_BITS_DEF];
  endfunction

endpackage

// File: rtl/led_afterglow_pwm_if.sv
// LED PIO word in, PWM pin drive out; master is the PIO side, slave is the driver.
interface led_afterglow_pwm_if import led_drv_pkg::*; #(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) ();

  logic [NUM_LEDS-1:0] led_in;
  logic [PWM_BITS-1:0] max_level;
  logic [NUM_LEDS-1:0] led_out;
  logic                fade_busy;

  modport master (
    output led_in,
    output max_level,
    input  led_out,
    input  fade_busy
  );

  modport slave (
    input  led_in,
    input  max_level,
    output led_out,
    output fade_busy
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with linear afterglow fade and the PWM compare flop.
// Optional macro LED_GAMMA_EN selects a square-law effective level instead of linear.
module led_pwm_channel import led_drv_pkg::*; #(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] max_level,
  input  logic                fade_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                busy
);

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] lvl_eff;
  logic                led_out_reg;

  // On-request wins, then the ceiling clamp, then the one-step fade that saturates at zero.
  always_comb begin
    level_next = level_reg;
    if (led_in) begin
      level_next = max_level;
    end else if (level_reg > max_level) begin
      level_next = max_level;
    end else if (fade_tick && (level_reg != '0)) begin
      level_next = level_reg - 1'b1;
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
  assign lvl_eff  = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign lvl_eff = level_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg   <= '0;
      led_out_reg <= 1'b0;
    end else begin
      level_reg   <= level_next;
      led_out_reg <= (lvl_eff > pwm_cnt);
    end
  end

  assign led_out = led_out_reg;
  assign busy    = ~led_in & (level_reg != '0);

endmodule

// File: rtl/led_afterglow_pwm.sv
// PWM-dimmed LED drive with global ceiling and linear fade-out after each LED turns off.
// Optional macro LED_GAMMA_EN enables a square-law brightness curve in every channel.
module led_afterglow_pwm import led_drv_pkg::*; #(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input logic                clk,
  input logic                reset_n,
  led_afterglow_pwm_if.slave bus
);

  // A one-bit counter that never leaves zero keeps FADE_DIV=1 ticking every cycle.
  localparam int              FC_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [FC_W-1:0] FADE_LAST = FC_W'(FADE_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [FC_W-1:0]     fade_cnt_reg;
  logic                fade_tick;
  logic [NUM_LEDS-1:0] busy_vec;
  logic [NUM_LEDS-1:0] led_out_vec;
  logic                fade_busy_reg;

  assign fade_tick = (fade_cnt_reg == FADE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_reg   <= '0;
      fade_cnt_reg  <= '0;
      fade_busy_reg <= 1'b0;
    end else begin
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      fade_cnt_reg  <= fade_tick ? '0 : fade_cnt_reg + 1'b1;
      fade_busy_reg <= |busy_vec;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      led_pwm_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (bus.led_in[gi]),
        .max_level (bus.max_level),
        .fade_tick (fade_tick),
        .pwm_cnt   (pwm_cnt_reg),
        .led_out   (led_out_vec[gi]),
        .busy      (busy_vec[gi])
      );
    end
  endgenerate

  assign bus.led_out   = led_out_vec;
  assign bus.fade_busy = fade_busy_reg;

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Directed bench for led_afterglow_pwm with FADE_DIV=4; LED_GAMMA_EN changes the duty expectations.
module tb_led_afterglow_pwm;

  localparam int NL = 14;
  localparam int PB = 8;
  localparam int FD = 4;

`ifdef LED_GAMMA_EN
  localparam int EXP_DUTY_80 = 64;
  localparam int EXP_DUTY_0F = 0;
`else
  localparam int EXP_DUTY_80 = 128;
  localparam int EXP_DUTY_0F = 15;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_afterglow_pwm_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) bus ();

  led_afterglow_pwm #(
    .NUM_LEDS (NL),
    .PWM_BITS (PB),
    .FADE_DIV (FD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Duty statistics over one full PWM period.
  int m_on0, m_on1, m_all, m_nz, m_hi, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed 0x%0h expected 0x%0h", vectors, tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
    $display("vec %0d %s: observed %0d expected %0d..%0d", vectors, tag, obs, lo, hi);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task measure();
    m_on0 = 0; m_on1 = 0; m_all = 0; m_nz = 0; m_hi = 0; m_busy = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (bus.led_out[0])            m_on0++;
      if (bus.led_out[1])            m_on1++;
      if (bus.led_out == '1)         m_all++;
      if (bus.led_out != '0)         m_nz++;
      if (bus.led_out[NL-1:1] != '0) m_hi++;
      if (bus.fade_busy)             m_busy++;
    end
  endtask

  // Cycles until fade_busy is seen low, capped so a stuck DUT still ends.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.fade_busy && n < 1000) begin
      step(1);
      n++;
    end
  endtask

  int n_idle;
  int guard;

  initial begin
    bus.led_in    = 14'h3FFF;
    bus.max_level = 8'hFF;

    // Reset held with everything requested on
    step(5);
    check("rst_led_out", 32'(bus.led_out), 32'h0);
    check("rst_busy", 32'(bus.fade_busy), 32'h0);
    step(3);
    check("rst_led_out_hold", 32'(bus.led_out), 32'h0);

    reset_n = 1'b1;
    step(1);
    check("rel_edge1_led_out", 32'(bus.led_out), 32'h0);
    step(1);
    check("rel_edge2_led_out", 32'(bus.led_out), 32'h3FFF);
    measure();
    check("full_duty_all", 32'(m_all), 32'd255);
    check("full_duty_nz", 32'(m_nz), 32'd255);
    check("full_busy", 32'(m_busy), 32'd0);

    // Duty 64/256 on channel 0; the others clamp to 0x40 and fade out first
    bus.max_level = 8'h40;
    bus.led_in    = 14'h0001;
    step(2);
    check("clamp_fade_busy", 32'(bus.fade_busy), 32'h1);
    step(298);
    check("others_idle", 32'(bus.fade_busy), 32'h0);
    measure();
    check("duty40_ch0", 32'(m_on0), 32'd64);
    check("duty40_hi", 32'(m_hi), 32'd0);

    // Fade of channel 0 from 0x40
    bus.led_in = 14'h0000;
    step(2);
    check("fade_busy_rise", 32'(bus.fade_busy), 32'h1);
    wait_idle(n_idle);
    check_range("fade_len_40", n_idle + 2, 254, 257);
    measure();
    check("faded_ch0_dark", 32'(m_nz), 32'd0);
    check("faded_busy", 32'(m_busy), 32'd0);

    // Re-assert mid-fade around 0x20
    bus.led_in = 14'h0001;
    step(4);
    bus.led_in = 14'h0000;
    step(130);
    check("midfade_busy", 32'(bus.fade_busy), 32'h1);
    bus.led_in = 14'h0001;
    step(2);
    check("reassert_busy", 32'(bus.fade_busy), 32'h0);
    measure();
    check("reassert_duty", 32'(m_on0), 32'd64);

    // Ceiling clamp while fading from 0xC0
    bus.max_level = 8'hC0;
    step(4);
    bus.led_in = 14'h0000;
    step(10);
    bus.max_level = 8'h10;
    step(2);
    check("clamp_busy", 32'(bus.fade_busy), 32'h1);
    wait_idle(n_idle);
    check_range("fade_len_10", n_idle + 2, 63, 66);

    bus.max_level = 8'h00;
    bus.led_in    = 14'h3FFF;
    step(3);
    measure();
    check("max0_dark", 32'(m_nz), 32'd0);
    check("max0_busy", 32'(m_busy), 32'd0);

    // Effective level on channel 1 (linear or square-law)
    bus.max_level = 8'h80;
    bus.led_in    = 14'h0002;
    step(3);
    measure();
    check("duty80_ch1", 32'(m_on1), 32'(EXP_DUTY_80));
    check("duty80_ch0", 32'(m_on0), 32'd0);
    bus.max_level = 8'h0F;
    step(3);
    measure();
    check("duty0F_ch1", 32'(m_on1), 32'(EXP_DUTY_0F));

    // Asynchronous reset in the middle of a fade
    bus.max_level = 8'hFF;
    bus.led_in    = 14'h3FFF;
    step(4);
    bus.led_in = 14'h0000;
    step(3);
    guard = 0;
    while (bus.led_out != 14'h3FFF && guard < 10) begin
      step(1);
      guard++;
    end
    check("prereset_led_out", 32'(bus.led_out), 32'h3FFF);
    check("prereset_busy", 32'(bus.fade_busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led_out", 32'(bus.led_out), 32'h0);
    check("async_rst_busy", 32'(bus.fade_busy), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(2);
    measure();
    check("post_rst_dark", 32'(m_nz), 32'd0);
    check("post_rst_busy", 32'(m_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
